// File: rtl/id_exe_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_exe_reg_pkg
// Shared types for the ID/EXE pipeline register:
//   - alu_op encodings
//   - packed ID/EXE payload struct and its bubble constant
//   - per-cycle action selector of the ID/EXE register
// ---------------------------------------------------------------------------
package id_exe_reg_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [2:0] {
    ALU_R_TYPE    = 3'b000,
    ALU_I_TYPE    = 3'b001,
    ALU_ADD_TYPE  = 3'b010,
    ALU_JALR_TYPE = 3'b011,
    ALU_B_TYPE    = 3'b100,
    ALU_LUI_TYPE  = 3'b110
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [2:0]        alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_exe_payload_t;

  // Harmless NOP-like entry: invalid, no side effects, add-type ALU op.
  localparam id_exe_payload_t ID_EXE_BUBBLE = '{
    valid:     1'b0,
    pc:        '0,
    rs1_data:  '0,
    rs2_data:  '0,
    imm:       '0,
    rs1:       '0,
    rs2:       '0,
    rd:        '0,
    funct3:    '0,
    funct7:    '0,
    alu_op:    ALU_ADD_TYPE,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_BUBBLE = 2'd1,
    ACT_FLUSH  = 2'd2,
    ACT_HOLD   = 2'd3
  } id_exe_action_e;

endpackage

// File: rtl/id_exe_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard detector. Flags when the instruction in EXE
// is a load whose destination is read by the instruction sitting in ID.
// Ports:
//   exe_valid, exe_mem_read, exe_rd  - load currently in EXE
//   id_valid, id_use_rs1/2, id_rs1/2 - consumer currently in ID
//   load_use                         - hazard flag
// ---------------------------------------------------------------------------
module load_use_detect
  import id_exe_reg_pkg::*;
(
  input  logic             exe_valid,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_rd,
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             load_use
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == exe_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == exe_rd);

  // x0 is never a real producer, so a load to x0 can never block a consumer.
  assign load_use = exe_valid && exe_mem_read && (exe_rd != '0) &&
                    id_valid && (rs1_match || rs2_match);

endmodule

// File: rtl/id_exe_reg.sv
// ---------------------------------------------------------------------------
// id_exe_reg
// ID/EXE pipeline register with hold, flush, load-use bubble insertion.
// Action priority per cycle: HOLD (mem_stall) > FLUSH (exe_branch_taken)
//   > BUBBLE (load-use hazard) > LOAD.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   id_*                - decoded instruction from ID
//   mem_stall           - downstream freeze (HOLD)
//   exe_branch_taken    - redirect from EXE (FLUSH)
//   exe_*               - registered instruction presented to EXE
//   hazard_stall        - freeze PC and IF/ID
// Optional feature (macro ID_EXE_PERF_EN):
//   perf_bubble_cnt     - saturating count of BUBBLE/FLUSH cycles
//   perf_hold_cnt       - saturating count of HOLD cycles
// ---------------------------------------------------------------------------
module id_exe_reg
  import id_exe_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [2:0]        id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              mem_stall,
  input  logic              exe_branch_taken,
  output logic              exe_valid,
  output logic [DATA_W-1:0] exe_pc,
  output logic [DATA_W-1:0] exe_rs1_data,
  output logic [DATA_W-1:0] exe_rs2_data,
  output logic [DATA_W-1:0] exe_imm,
  output logic [REG_W-1:0]  exe_rs1,
  output logic [REG_W-1:0]  exe_rs2,
  output logic [REG_W-1:0]  exe_rd,
  output logic [2:0]        exe_funct3,
  output logic [6:0]        exe_funct7,
  output logic [2:0]        exe_alu_op,
  output logic              exe_reg_write,
  output logic              exe_mem_read,
  output logic              exe_mem_write,
  output logic              hazard_stall
`ifdef ID_EXE_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt,
  output logic [31:0]       perf_hold_cnt
`endif
);

  id_exe_payload_t payload_p0;
  id_exe_payload_t payload_p1;
  id_exe_payload_t next_p0;
  id_exe_action_e  action_p0;
  logic            load_use_p0;

  // ---- stage p0: ID side, hazard detection and action select ----
  load_use_detect u_load_use_detect (
    .exe_valid    (payload_p1.valid),
    .exe_mem_read (payload_p1.mem_read),
    .exe_rd       (payload_p1.rd),
    .id_valid     (id_valid),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .load_use     (load_use_p0)
  );

  always_comb begin
    payload_p0 = '{
      valid:     id_valid,
      pc:        id_pc,
      rs1_data:  id_rs1_data,
      rs2_data:  id_rs2_data,
      imm:       id_imm,
      rs1:       id_rs1,
      rs2:       id_rs2,
      rd:        id_rd,
      funct3:    id_funct3,
      funct7:    id_funct7,
      alu_op:    id_alu_op,
      reg_write: id_reg_write,
      mem_read:  id_mem_read,
      mem_write: id_mem_write
    };
  end

  always_comb begin
    action_p0 = ACT_LOAD;
    if (mem_stall)             action_p0 = ACT_HOLD;
    else if (exe_branch_taken) action_p0 = ACT_FLUSH;
    else if (load_use_p0)      action_p0 = ACT_BUBBLE;
  end

  // An invalid ID slot is loaded as a clean bubble so stale fields never
  // reach EXE.
  always_comb begin
    next_p0 = ID_EXE_BUBBLE;
    if (action_p0 == ACT_LOAD && id_valid) next_p0 = payload_p0;
  end

  // A taken branch squashes the consumer anyway, so a coincident load-use
  // stall is suppressed; the bubble in EXE makes the stall last one cycle.
  assign hazard_stall = mem_stall | (load_use_p0 & ~exe_branch_taken);

  // ---- stage p1: EXE side register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      payload_p1 <= ID_EXE_BUBBLE;
    end else if (action_p0 != ACT_HOLD) begin
      payload_p1 <= next_p0;
    end
  end

  assign exe_valid     = payload_p1.valid;
  assign exe_pc        = payload_p1.pc;
  assign exe_rs1_data  = payload_p1.rs1_data;
  assign exe_rs2_data  = payload_p1.rs2_data;
  assign exe_imm       = payload_p1.imm;
  assign exe_rs1       = payload_p1.rs1;
  assign exe_rs2       = payload_p1.rs2;
  assign exe_rd        = payload_p1.rd;
  assign exe_funct3    = payload_p1.funct3;
  assign exe_funct7    = payload_p1.funct7;
  assign exe_alu_op    = payload_p1.alu_op;
  assign exe_reg_write = payload_p1.reg_write;
  assign exe_mem_read  = payload_p1.mem_read;
  assign exe_mem_write = payload_p1.mem_write;

`ifdef ID_EXE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_hold_cnt   <= '0;
    end else begin
      if (action_p0 == ACT_BUBBLE || action_p0 == ACT_FLUSH)
        perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      if (action_p0 == ACT_HOLD)
        perf_hold_cnt <= sat_inc(perf_hold_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_exe_reg
// Self-checking bench for id_exe_reg: reset sequence, a directed vector
// table covering load-use, x0, unused operand, flush and hold priority,
// then randomized cycles against a behavioural model.
// Optional: define ID_EXE_PERF_EN to also check the perf counters.
// ---------------------------------------------------------------------------
module tb_id_exe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [2:0]  id_funct3 = '0;
  logic [6:0]  id_funct7 = '0;
  logic [2:0]  id_alu_op = '0;
  logic        id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic        mem_stall = 1'b0, exe_branch_taken = 1'b0;
  logic        exe_valid;
  logic [31:0] exe_pc, exe_rs1_data, exe_rs2_data, exe_imm;
  logic [4:0]  exe_rs1, exe_rs2, exe_rd;
  logic [2:0]  exe_funct3;
  logic [6:0]  exe_funct7;
  logic [2:0]  exe_alu_op;
  logic        exe_reg_write, exe_mem_read, exe_mem_write;
  logic        hazard_stall;
`ifdef ID_EXE_PERF_EN
  logic [31:0] perf_bubble_cnt, perf_hold_cnt;
  logic [31:0] bub0, hold0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .mem_stall(mem_stall), .exe_branch_taken(exe_branch_taken),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_rs1_data(exe_rs1_data),
    .exe_rs2_data(exe_rs2_data), .exe_imm(exe_imm), .exe_rs1(exe_rs1),
    .exe_rs2(exe_rs2), .exe_rd(exe_rd), .exe_funct3(exe_funct3),
    .exe_funct7(exe_funct7), .exe_alu_op(exe_alu_op),
    .exe_reg_write(exe_reg_write), .exe_mem_read(exe_mem_read),
    .exe_mem_write(exe_mem_write), .hazard_stall(hazard_stall)
`ifdef ID_EXE_PERF_EN
    , .perf_bubble_cnt(perf_bubble_cnt), .perf_hold_cnt(perf_hold_cnt)
`endif
  );

  task automatic chk(input string name, input logic [191:0] act,
                     input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---- directed vector table ----
  typedef struct {
    logic        ms, bt, iv;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, mr;
    logic        exp_hz;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [4:0]  exp_rd;
    logic        exp_mr;
  } vec_t;

  vec_t tbl[16];

  // ---- behavioural model of what EXE should hold ----
  typedef struct {
    logic        v;
    logic [31:0] pc, r1d, r2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  alu;
    logic        rw, mr, mw;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t bubble();
    mdl_t b;
    b = '{v: 1'b0, pc: 0, r1d: 0, r2d: 0, imm: 0, rs1: 0, rs2: 0, rd: 0,
          f3: 0, f7: 0, alu: 3'b010, rw: 1'b0, mr: 1'b0, mw: 1'b0};
    return b;
  endfunction

  function automatic logic model_hazard();
    if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
    return (id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd);
  endfunction

  function automatic logic [191:0] dut_bus();
    return {exe_valid, exe_pc, exe_rs1_data, exe_rs2_data, exe_imm, exe_rs1,
            exe_rs2, exe_rd, exe_funct3, exe_funct7, exe_alu_op,
            exe_reg_write, exe_mem_read, exe_mem_write};
  endfunction

  function automatic logic [191:0] mdl_bus();
    return {m.v, m.pc, m.r1d, m.r2d, m.imm, m.rs1, m.rs2, m.rd, m.f3, m.f7,
            m.alu, m.rw, m.mr, m.mw};
  endfunction

  initial begin
    //          ms bt iv pc          rd rs1 rs2 u1 u2 mr  hz v  exp_pc      rd mr
    tbl[0]  = '{0, 0, 1, 32'h100,    5, 1,  0,  1, 0, 1,  0, 1, 32'h100,    5, 1};
    tbl[1]  = '{0, 0, 1, 32'h104,    6, 5,  0,  1, 0, 0,  1, 0, 32'h0,      0, 0};
    tbl[2]  = '{0, 0, 1, 32'h104,    6, 5,  0,  1, 0, 0,  0, 1, 32'h104,    6, 0};
    tbl[3]  = '{0, 0, 1, 32'h108,    0, 1,  0,  1, 0, 1,  0, 1, 32'h108,    0, 1};
    tbl[4]  = '{0, 0, 1, 32'h10c,    3, 0,  0,  1, 0, 0,  0, 1, 32'h10c,    3, 0};
    tbl[5]  = '{0, 0, 1, 32'h110,    7, 1,  0,  1, 0, 1,  0, 1, 32'h110,    7, 1};
    tbl[6]  = '{0, 0, 1, 32'h114,    8, 1,  7,  1, 0, 0,  0, 1, 32'h114,    8, 0};
    tbl[7]  = '{0, 0, 1, 32'h118,    9, 1,  0,  1, 0, 1,  0, 1, 32'h118,    9, 1};
    tbl[8]  = '{0, 1, 1, 32'h11c,    2, 1,  9,  0, 1, 0,  0, 0, 32'h0,      0, 0};
    tbl[9]  = '{0, 0, 1, 32'h120,    4, 1,  0,  1, 0, 1,  0, 1, 32'h120,    4, 1};
    tbl[10] = '{1, 1, 1, 32'h124,    2, 4,  0,  1, 0, 0,  1, 1, 32'h120,    4, 1};
    tbl[11] = '{1, 1, 1, 32'h124,    2, 4,  0,  1, 0, 0,  1, 1, 32'h120,    4, 1};
    tbl[12] = '{1, 1, 1, 32'h124,    2, 4,  0,  1, 0, 0,  1, 1, 32'h120,    4, 1};
    tbl[13] = '{0, 1, 1, 32'h124,    2, 4,  0,  1, 0, 0,  0, 0, 32'h0,      0, 0};
    tbl[14] = '{0, 0, 0, 32'h128,    2, 1,  0,  1, 0, 1,  0, 0, 32'h0,      0, 0};
    tbl[15] = '{0, 0, 1, 32'h12c,    2, 1,  0,  1, 0, 0,  0, 1, 32'h12c,    2, 0};
  end

  initial begin
    // ---- reset: drive a live instruction, then reset mid-cycle ----
    @(negedge clk);
    id_valid = 1'b1; id_pc = 32'h55; id_alu_op = 3'b000; id_rd = 5'd3;
    id_reg_write = 1'b1;
    @(posedge clk); #1;
    chk("pre_reset_pc", 192'(exe_pc), 192'(32'h55));
    #2 rst_n = 1'b0; mem_stall = 1'b0;
    #1;
    chk("reset_valid", 192'(exe_valid), 192'(1'b0));
    chk("reset_alu_op", 192'(exe_alu_op), 192'(3'b010));
    chk("reset_pc", 192'(exe_pc), 192'(32'h0));
    chk("reset_reg_write", 192'(exe_reg_write), 192'(1'b0));
    chk("reset_hz_idle", 192'(hazard_stall), 192'(1'b0));
    mem_stall = 1'b1; #1;
    chk("reset_hz_memstall", 192'(hazard_stall), 192'(1'b1));
`ifdef ID_EXE_PERF_EN
    chk("reset_perf_bub", 192'(perf_bubble_cnt), 192'(0));
    chk("reset_perf_hold", 192'(perf_hold_cnt), 192'(0));
`endif
    @(negedge clk);
    mem_stall = 1'b0; rst_n = 1'b1;
    id_valid = 1'b1; id_pc = 32'h100; id_alu_op = 3'b000;
    @(posedge clk); #1;
    chk("load_pc", 192'(exe_pc), 192'(32'h100));
    chk("load_alu_op", 192'(exe_alu_op), 192'(3'b000));
    chk("load_valid", 192'(exe_valid), 192'(1'b1));

    // start the table from a clean bubble in EXE
    rst_n = 1'b0; #1 rst_n = 1'b1;
    id_alu_op = 3'b001; id_funct3 = 3'd2; id_reg_write = 1'b1;
    id_mem_write = 1'b0; id_rs1_data = 32'hA; id_rs2_data = 32'hB;
    id_imm = 32'hC; id_funct7 = 7'h20;

    // ---- directed table ----
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mem_stall = tbl[i].ms; exe_branch_taken = tbl[i].bt;
      id_valid = tbl[i].iv; id_pc = tbl[i].pc; id_rd = tbl[i].rd;
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2;
      id_mem_read = tbl[i].mr;
`ifdef ID_EXE_PERF_EN
      if (i == 10) begin bub0 = perf_bubble_cnt; hold0 = perf_hold_cnt; end
`endif
      #1;
      chk($sformatf("tbl%0d_hazard", i), 192'(hazard_stall), 192'(tbl[i].exp_hz));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_exe", i), 192'({exe_valid, exe_pc, exe_rd, exe_mem_read}),
          192'({tbl[i].exp_v, tbl[i].exp_pc, tbl[i].exp_rd, tbl[i].exp_mr}));
      if (!tbl[i].exp_v)
        chk($sformatf("tbl%0d_bubble_alu", i), 192'({exe_alu_op, exe_reg_write, exe_imm}),
            192'({3'b010, 1'b0, 32'h0}));
`ifdef ID_EXE_PERF_EN
      if (i == 13) begin
        chk("perf_hold_delta", 192'(perf_hold_cnt - hold0), 192'(3));
        chk("perf_bubble_delta", 192'(perf_bubble_cnt - bub0), 192'(1));
      end
`endif
    end

    // ---- randomized cycles against the model ----
    rst_n = 1'b0; #1 rst_n = 1'b1;
    m = bubble();
    for (int c = 0; c < 400; c++) begin
      logic hz_exp;
      @(negedge clk);
      mem_stall        = ($urandom_range(0, 4) == 0);
      exe_branch_taken = ($urandom_range(0, 7) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_pc        = $urandom; id_rs1_data = $urandom;
      id_rs2_data  = $urandom; id_imm = $urandom;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom); id_use_rs2 = 1'($urandom);
      id_funct3    = 3'($urandom); id_funct7 = 7'($urandom);
      id_alu_op    = 3'($urandom); id_reg_write = 1'($urandom);
      id_mem_read  = 1'($urandom); id_mem_write = 1'($urandom);
      #1;
      hz_exp = model_hazard();
      chk("rand_hazard", 192'(hazard_stall),
          192'(mem_stall || (hz_exp && !exe_branch_taken)));
      if (!mem_stall) begin
        if (exe_branch_taken || hz_exp || !id_valid) m = bubble();
        else m = '{v: 1'b1, pc: id_pc, r1d: id_rs1_data, r2d: id_rs2_data,
                   imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                   f3: id_funct3, f7: id_funct7, alu: id_alu_op,
                   rw: id_reg_write, mr: id_mem_read, mw: id_mem_write};
      end
      @(posedge clk); #1;
      chk("rand_exe", dut_bus(), mdl_bus());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // absolute time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have these ports (name direction width meaning): clk in 1 clock; rst_n in 1 async active-low reset.
REQ-003 The block SHALL have these decode-side inputs: id_valid 1; id_pc 32; id_rs1_data 32; id_rs2_data 32; id_imm 32; id_rs1 5; id_rs2 5; id_rd 5; id_use_rs1 1; id_use_rs2 1; id_funct3 3; id_funct7 7; id_alu_op 3; id_reg_write 1; id_mem_read 1; id_mem_write 1.
REQ-004 The block SHALL have these control inputs: mem_stall in 1 (downstream freeze); exe_branch_taken in 1 (redirect from execute).
REQ-005 The block SHALL have these outputs: exe_valid 1; exe_pc, exe_rs1_data, exe_rs2_data, exe_imm 32; exe_rs1, exe_rs2, exe_rd 5; exe_funct3 3; exe_funct7 7; exe_alu_op 3; exe_reg_write, exe_mem_read, exe_mem_write 1; hazard_stall out 1 (freeze PC and IF/ID).

Function
REQ-006 The block SHALL register every id_* field into its exe_* counterpart on the rising clk edge when in LOAD action.
REQ-007 The block SHALL select one action per cycle, with priority: HOLD (mem_stall=1) > FLUSH (exe_branch_taken=1) > BUBBLE (load-use hazard) > LOAD.
REQ-008 In HOLD, all exe_* SHALL keep their values; a pending flush SHALL take effect in the first cycle with mem_stall=0, because exe_branch_taken stays asserted.
REQ-009 FLUSH and BUBBLE SHALL write the bubble pattern: exe_valid=0; reg_write, mem_read, mem_write=0; alu_op=3'b010 (add_type); all other fields 0.
REQ-010 Load-use hazard SHALL be (combinational): exe_valid & exe_mem_read & exe_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==exe_rd) | (id_use_rs2 & id_rs2==exe_rd)).
REQ-011 hazard_stall SHALL equal load-use hazard OR mem_stall, and SHALL be forced 0 when exe_branch_taken=1 and mem_stall=0.
REQ-012 Load-use stall SHALL last exactly one cycle per load; the bubble clears exe_mem_read, so the next cycle sees no hazard and loads the held ID entry.
REQ-013 id_valid=0 in LOAD SHALL load the bubble pattern regardless of other id_* values.
REQ-014 Register x0 as destination (exe_rd=0) SHALL never raise a hazard.
REQ-015 Latency ID->EXE SHALL be one cycle; there SHALL be no combinational path from id_* to exe_*.

Reset
REQ-016 rst_n=0 SHALL asynchronously load the bubble pattern into all exe_* outputs.
REQ-017 Reset SHALL clear the perf counters when present.
REQ-018 An instruction in flight at reset SHALL be discarded.
REQ-019 hazard_stall SHALL be 0 during reset unless mem_stall=1.

Configuration
REQ-020 With macro ID_EXE_PERF_EN defined, the block SHALL add outputs perf_bubble_cnt 32 and perf_hold_cnt 32.
REQ-021 perf_bubble_cnt SHALL increment on each BUBBLE or FLUSH cycle, and perf_hold_cnt SHALL increment on each HOLD cycle; both SHALL saturate at 32'hFFFF_FFFF.
REQ-022 Without ID_EXE_PERF_EN, the counters and ports SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-023 A shared package SHALL hold: alu_op encodings (r_type 000, i_type 001, add_type 010, jalr_type 011, b_type 100, lui_type 110); the packed ID/EXE payload struct; the bubble constant of that struct.
REQ-024 Load-use detection SHALL be one combinational sub-module, load_use_detect; the payload register and the action mux SHALL stay in id_exe_reg.

Verification
REQ-025 Reset then LOAD: assert rst_n=0 mid-cycle -> exe_valid=0 and exe_alu_op=010 immediately; then id_valid=1, id_pc=0x100, id_alu_op=000 -> next cycle exe_pc=0x100, exe_alu_op=000.
REQ-026 Load-use: exe holds lw rd=5; ID has add with rs1=5, id_use_rs1=1 -> hazard_stall=1 for one cycle, one bubble; the add appears in EXE the following cycle.
REQ-027 x0 and unused operand: exe lw rd=0 with id_rs1=0 -> no stall; exe lw rd=7 with id_rs2=7 and id_use_rs2=0 -> no stall.
REQ-028 Flush vs hazard: exe_branch_taken=1 together with a load-use hazard -> bubble loaded, hazard_stall=0.
REQ-029 Hold priority: mem_stall=1 for 3 cycles with exe_branch_taken=1 -> exe_* unchanged for 3 cycles, then flush; with ID_EXE_PERF_EN, perf_hold_cnt=3 and perf_bubble_cnt=1.
